psram_responder: RTL

SPI-side responder for the pComputer PSRAM bus: the device end of the `psram_ce`/`psram_sclk`/`psram_mosi`/`psram_miso` link driven by the CPU's PSRAM controller. It decodes single-line (SPI mode 0) APS6404-style commands and serves them from an internal block-RAM array. It sits in the simulation top and in FPGA builds without a physical PSRAM, so the controller can be exercised end to end. Quad lines `sio2`/`sio3` are not driven.

---
 rtl/psram_pkg.sv | 14 +
 rtl/spi_pin_sync.sv | 41 ++++
 rtl/psram_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: opcodes, phase lengths and FSM states shared by the PSRAM responder.
package psram_pkg;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FREAD = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDID  = 8'h9F;
    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam int DUMMY_CYC = 8;
    localparam int ADDR_BITS = 24;
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IDOUT, S_IGNORE
    } state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizers for the SPI pins plus registered edge strobes.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ce_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic ce_fall_o,
    output logic ce_rise_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic mosi_o
);
    logic [2:0] ce_q, sclk_q, mosi_q;
    logic       ce_fall_q, ce_rise_q, rise_q, fall_q;
    // ce resets low so a ce held low across reset never looks like a new falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q      <= '0;
            sclk_q    <= '0;
            mosi_q    <= '0;
            ce_fall_q <= 1'b0;
            ce_rise_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            ce_q      <= {ce_q[1:0], ce_i};
            sclk_q    <= {sclk_q[1:0], sclk_i};
            mosi_q    <= {mosi_q[1:0], mosi_i};
            ce_fall_q <= ~ce_q[1] & ce_q[2];
            ce_rise_q <= ce_q[1] & ~ce_q[2];
            rise_q    <= sclk_q[1] & ~sclk_q[2];
            fall_q    <= ~sclk_q[1] & sclk_q[2];
        end
    end
    assign ce_fall_o   = ce_fall_q;
    assign ce_rise_o   = ce_rise_q;
    assign sclk_rise_o = rise_q;
    assign sclk_fall_o = fall_q;
    assign mosi_o      = mosi_q[2];
endmodule

// File: rtl/psram_responder.sv
// psram_responder: APS6404-style single-line SPI PSRAM device model backed by block RAM.
module psram_responder
    import psram_pkg::*;
#(
    parameter int         ADDR_W = 16,
    parameter logic [7:0] MFID   = 8'h0D,
    parameter logic [7:0] KGD    = 8'h5D
) (
    input  logic clk,
    input  logic rst_n,
    input  logic psram_ce,
    input  logic psram_sclk,
    input  logic psram_mosi,
    output logic psram_miso,
    output logic psram_miso_oe,
    output logic busy
);
    logic ce_fall, ce_rise, rise, fall, mosi;
    spi_pin_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce_i       (psram_ce),
        .sclk_i     (psram_sclk),
        .mosi_i     (psram_mosi),
        .ce_fall_o  (ce_fall),
        .ce_rise_o  (ce_rise),
        .sclk_rise_o(rise),
        .sclk_fall_o(fall),
        .mosi_o     (mosi)
    );
    state_e              state_q, state_d;
    logic [4:0]          bit_q, bit_d;
    logic [ADDR_BITS-2:0] sh_q, sh_d;
    logic [7:0]          cmd_q, cmd_d, tx_q, tx_d;
    logic [2:0]          tx_cnt_q, tx_cnt_d;
    logic [1:0]          id_q, id_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d, ram_addr;
    logic                rst_en_q, rst_en_d, miso_q, miso_d, oe_q, oe_d;
    logic                ram_we, ram_re;
    logic [7:0]          ram_wdata, rdata_q, id_byte, tx_src;
    logic [ADDR_BITS-1:0] sh_in;
    logic [7:0]          mem [2**ADDR_W];
    assign sh_in   = {sh_q, mosi};
    assign id_byte = id_q == 2'd0 ? MFID : id_q == 2'd1 ? KGD : 8'h00;
    assign tx_src  = state_q == S_IDOUT ? id_byte : rdata_q;
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        tx_cnt_d  = tx_cnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        rst_en_d  = rst_en_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = ptr_q;
        ram_wdata = sh_in[7:0];
        if (ce_rise) begin
            state_d  = S_IDLE;
            bit_d    = '0;
            tx_cnt_d = '0;
            oe_d     = 1'b0;
        end else begin
            if (rise && state_q inside {S_CMD, S_ADDR, S_DUMMY, S_WDATA}) begin
                sh_d  = sh_in[ADDR_BITS-2:0];
                bit_d = bit_q + 5'd1;
            end
            case (state_q)
                S_IDLE: if (ce_fall) begin
                    state_d = S_CMD;
                    bit_d   = '0;
                    id_d    = '0;
                end
                S_CMD: if (rise && bit_q == 5'd7) begin
                    bit_d    = '0;
                    cmd_d    = sh_in[7:0];
                    rst_en_d = sh_in[7:0] == CMD_RSTEN;
                    state_d  = sh_in[7:0] inside {CMD_READ, CMD_FREAD, CMD_WRITE, CMD_RDID} ? S_ADDR : S_IGNORE;
                    if (sh_in[7:0] == CMD_RST && rst_en_q) ptr_d = '0;
                end
                S_ADDR: if (rise && bit_q == 5'(ADDR_BITS - 1)) begin
                    bit_d    = '0;
                    ptr_d    = cmd_q == CMD_RDID ? ptr_q : sh_in[ADDR_W-1:0];
                    ram_addr = sh_in[ADDR_W-1:0];
                    ram_re   = cmd_q == CMD_READ;
                    state_d  = cmd_q == CMD_READ  ? S_RDATA :
                               cmd_q == CMD_FREAD ? S_DUMMY :
                               cmd_q == CMD_WRITE ? S_WDATA : S_IDOUT;
                end
                S_DUMMY: if (rise && bit_q == 5'(DUMMY_CYC - 1)) begin
                    bit_d   = '0;
                    ram_re  = 1'b1;
                    state_d = S_RDATA;
                end
                S_WDATA: if (rise && bit_q == 5'd7) begin
                    bit_d  = '0;
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end
                S_RDATA, S_IDOUT: if (fall) begin
                    oe_d     = 1'b1;
                    miso_d   = tx_cnt_q == 3'd0 ? tx_src[7] : tx_q[7];
                    tx_d     = tx_cnt_q == 3'd0 ? {tx_src[6:0], 1'b0} : {tx_q[6:0], 1'b0};
                    tx_cnt_d = tx_cnt_q + 3'd1;
                    // bit 0 just went out: advance and prefetch well ahead of the next fall
                    if (tx_cnt_q == 3'd7 && state_q == S_RDATA) begin
                        ptr_d    = ptr_q + 1'b1;
                        ram_re   = 1'b1;
                        ram_addr = ptr_q + 1'b1;
                    end
                    if (tx_cnt_q == 3'd7 && state_q == S_IDOUT) id_d = id_q == 2'd2 ? id_q : id_q + 2'd1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            sh_q     <= '0;
            cmd_q    <= '0;
            tx_q     <= '0;
            tx_cnt_q <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            rst_en_q <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            cmd_q    <= cmd_d;
            tx_q     <= tx_d;
            tx_cnt_q <= tx_cnt_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            rst_en_q <= rst_en_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
        end
    end
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) rdata_q <= mem[ram_addr];
    end
    assign psram_miso    = miso_q;
    assign psram_miso_oe = oe_q;
    assign busy          = state_q != S_IDLE;
endmodule
